// File: rtl/unipolar_rz_rx.sv
// unipolar_rz_rx: receiver/decoder for a unipolar return-to-zero single-wire line.
// Oversamples the line, classifies each high pulse as 0/1 by width, and packs
// bits LSB-first into DATA_WIDTH-bit words. Line resets and illegal pulses are flagged.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   line         raw asynchronous RZ line
//   data         last completed word, first received bit in data[0]
//   valid        one-cycle pulse, data updated this cycle
//   reset_seen   one-cycle pulse when a line reset (long idle) is detected
//   symbol_error one-cycle pulse on an illegal pulse width or truncated word
module unipolar_rz_rx #(
    parameter int  DATA_WIDTH     = 24,
    parameter int  CLOCK_RATE     = 50_000_000,
    parameter real ZERO_HIGH_TIME = 0.4e-6,
    parameter real ONE_HIGH_TIME  = 0.8e-6,
    parameter real RESET_TIME     = 50.0e-6,
    parameter bit  INVERT         = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  reset_seen,
    output logic                  symbol_error
);

    localparam int Z_CYC  = int'(real'(CLOCK_RATE) * ZERO_HIGH_TIME);
    localparam int O_CYC  = int'(real'(CLOCK_RATE) * ONE_HIGH_TIME);
    localparam int R_CYC  = int'(real'(CLOCK_RATE) * RESET_TIME);
    localparam int THRESH = (Z_CYC + O_CYC) / 2;
    localparam int MIN_HI = (Z_CYC / 2 < 1) ? 1 : Z_CYC / 2;
    localparam int MAX_HI = 2 * O_CYC;
    localparam int RST_DET = R_CYC / 2;
    // High counter must be able to hold MAX_HI+1 (its saturation value).
    localparam int CNT_TOP = (MAX_HI + 1 > RST_DET) ? MAX_HI + 1 : RST_DET;
    localparam int CW      = $clog2(CNT_TOP + 1);
    localparam int BW      = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_HI);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_HI);
    localparam logic [CW-1:0] HSAT_C   = CW'(MAX_HI + 1);
    localparam logic [CW-1:0] RDET_C   = CW'(RST_DET);
    localparam logic [BW-1:0] LAST_C   = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_BITS
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_sync1;
    logic r_sync2;
    logic r_sync_d;
    logic w_ln;
    logic w_ln_d;
    logic w_rise;
    logic w_fall;

    logic [CW-1:0] r_high;
    logic [CW-1:0] r_low;
    logic          r_low_done;

    logic [DATA_WIDTH-2:0] r_shift;
    logic [BW-1:0]         r_bitcnt;

    logic                  w_active;
    logic                  w_low_hit;
    logic                  w_high_over;
    logic                  w_bad_fall;
    logic                  w_good_fall;
    logic                  w_bit;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_valid_n;
    logic                  w_rs_n;
    logic                  w_err_n;

    // Synchroniser and delayed copy are kept in the raw domain so that
    // they reset to the idle level of the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= INVERT;
            r_sync2  <= INVERT;
            r_sync_d <= INVERT;
        end else begin
            r_sync1  <= line;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_ln   = r_sync2 ^ INVERT;
    assign w_ln_d = r_sync_d ^ INVERT;
    assign w_rise = w_ln & ~w_ln_d;
    assign w_fall = ~w_ln & w_ln_d;

    // Counters restart at 1 on the edge cycle so they hold the exact
    // number of cycles spent at the level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_high     <= '0;
            r_low      <= '0;
            r_low_done <= 1'b0;
        end else begin
            if (w_ln) begin
                if (w_rise)
                    r_high <= CW'(1);
                else if (r_high != HSAT_C)
                    r_high <= r_high + 1'b1;
            end else begin
                if (w_fall)
                    r_low <= CW'(1);
                else if (r_low != RDET_C)
                    r_low <= r_low + 1'b1;
            end
            if (w_fall)
                r_low_done <= 1'b0;
            else if (w_low_hit)
                r_low_done <= 1'b1;
        end
    end

    assign w_active    = (r_state != S_SYNC);
    // r_low_done limits the line-reset event to once per low period.
    assign w_low_hit   = ~w_ln & (r_low == RDET_C) & ~r_low_done;
    // Excluding the rise cycle ignores a stale count from the previous pulse.
    assign w_high_over = w_ln & ~w_rise & (r_high == MAX_C);
    assign w_bad_fall  = w_active & w_fall &
                         ((r_high < MIN_C) | (r_high > MAX_C));
    assign w_good_fall = w_active & w_fall & ~w_bad_fall;
    assign w_bit       = (r_high >= THRESH_C);
    assign w_last      = (r_bitcnt == LAST_C);
    assign w_word      = {w_bit, r_shift};

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_SYNC;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_SYNC: begin
                if (w_low_hit)
                    w_state_next = S_IDLE;
            end
            S_IDLE, S_BITS: begin
                if (w_low_hit)
                    w_state_next = S_IDLE;
                else if (w_high_over || w_bad_fall)
                    w_state_next = S_SYNC;
                else if (w_good_fall)
                    w_state_next = w_last ? S_IDLE : S_BITS;
            end
            default: w_state_next = S_SYNC;
        endcase
    end

    always_comb begin
        w_valid_n = w_good_fall & w_last;
        w_rs_n    = w_low_hit;
        w_err_n   = w_bad_fall |
                    (w_active & w_high_over) |
                    (w_low_hit & (r_state == S_BITS));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data         <= '0;
            valid        <= 1'b0;
            reset_seen   <= 1'b0;
            symbol_error <= 1'b0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
        end else begin
            valid        <= w_valid_n;
            reset_seen   <= w_rs_n;
            symbol_error <= w_err_n;
            if (w_good_fall) begin
                r_shift  <= w_word[DATA_WIDTH-1:1];
                r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
                if (w_last)
                    data <= w_word;
            end
            if (w_low_hit || w_err_n)
                r_bitcnt <= '0;
        end
    end

endmodule
